// File: rtl/dffram_lsu_if.sv
// Bundle between the load/store front end, its requester/consumer and the byte-write data RAM.
// Handshakes: a beat moves on a rising edge where valid & ready are both high; valid is held with payload stable until then.
interface dffram_lsu_if #(
   parameter int ADDRESS_LENGTH = 11
);
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [2:0]                req_funct3;
   logic [31:0]               req_addr;
   logic [31:0]               req_wdata;
   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [31:0]               rsp_rdata;
   logic                      rsp_err;
   logic                      ram_en;
   logic [3:0]                ram_we;
   logic [ADDRESS_LENGTH-1:0] ram_a;
   logic [31:0]               ram_di;
   logic [31:0]               ram_do;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_do,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_en, ram_we, ram_a, ram_di
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, ram_do,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_en, ram_we, ram_a, ram_di
   );
endinterface

// File: rtl/dffram_lsu.sv
// Load/store front end for a 2**ADDRESS_LENGTH x 32 byte-write RAM with a registered read port.
// One request in flight: IDLE accepts, LOAD_WAIT extracts ram_do, RESP holds the response.
module dffram_lsu #(
   parameter int ADDRESS_LENGTH = 11,
   parameter int DATA_LENGTH    = 32
) (
   input  logic               CLK,
   input  logic               RST,
   dffram_lsu_if.slave        bus,
   output logic [1:0]         dbg_state
);
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LOAD_WAIT = 2'd1,
      RESP      = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [1:0]             off_q, off_d;
   logic [2:0]             f3_q, f3_d;
   logic [DATA_LENGTH-1:0] rdata_q, rdata_d;
   logic                   err_q, err_d;

   logic                   accept;
   logic                   req_bad;
   logic                   misalign;
   logic                   illegal;
   logic [7:0]             byte_sel;
   logic [15:0]            half_sel;
   logic [DATA_LENGTH-1:0] load_ext;
   logic                   unused_addr_hi;

   // Upper address bits wrap onto the RAM and are deliberately ignored.
   assign unused_addr_hi = ^bus.req_addr[31:ADDRESS_LENGTH+2];

   assign accept    = bus.req_valid && (state_q == IDLE) && !RST;
   assign dbg_state = state_q;

   always_comb begin
      misalign = 1'b0;
      case (bus.req_funct3)
         3'd1, 3'd5: misalign = bus.req_addr[0];
         3'd2:       misalign = (bus.req_addr[1:0] != 2'b00);
         default:    misalign = 1'b0;
      endcase
      if (bus.req_we) illegal = (bus.req_funct3 > 3'd2);
      else            illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3 == 3'd6) ||
                                (bus.req_funct3 == 3'd7);
      req_bad = misalign || illegal;
   end

   always_comb begin
      byte_sel = bus.ram_do[{off_q, 3'b000} +: 8];
      half_sel = off_q[1] ? bus.ram_do[31:16] : bus.ram_do[15:0];
      case (f3_q)
         3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
         3'd4:    load_ext = {24'd0, byte_sel};
         3'd5:    load_ext = {16'd0, half_sel};
         default: load_ext = bus.ram_do;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         off_q   <= 2'd0;
         f3_q    <= 3'd0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      f3_d    = f3_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_bad || bus.req_we) begin
                  state_d = RESP;
                  err_d   = req_bad;
                  rdata_d = '0;
               end else begin
                  state_d = LOAD_WAIT;
                  off_d   = bus.req_addr[1:0];
                  f3_d    = bus.req_funct3;
               end
            end
         end
         LOAD_WAIT: begin
            state_d = RESP;
            rdata_d = load_ext;
            err_d   = 1'b0;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // RAM is driven only in the accepting cycle of a legal request.
   always_comb begin
      bus.req_ready = (state_q == IDLE) && !RST;
      bus.rsp_valid = (state_q == RESP);
      bus.rsp_rdata = rdata_q;
      bus.rsp_err   = err_q;
      bus.ram_en    = 1'b0;
      bus.ram_we    = 4'b0000;
      bus.ram_a     = '0;
      bus.ram_di    = 32'd0;
      if (accept && !req_bad) begin
         bus.ram_en = 1'b1;
         bus.ram_a  = bus.req_addr[ADDRESS_LENGTH+1:2];
         if (bus.req_we) begin
            case (bus.req_funct3)
               3'd0: begin
                  bus.ram_we = 4'b0001 << bus.req_addr[1:0];
                  bus.ram_di = {4{bus.req_wdata[7:0]}};
               end
               3'd1: begin
                  bus.ram_we = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                  bus.ram_di = {2{bus.req_wdata[15:0]}};
               end
               default: begin
                  bus.ram_we = 4'b1111;
                  bus.ram_di = bus.req_wdata;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dffram_lsu.sv
// Bench for dffram_lsu: byte-array reference model, scoreboard queue, RAM model and response monitor.
module tb_dffram_lsu;
   localparam int AL = 11;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  dbg_state;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          stall_req = 0;
   bit          have_cur = 0;
   exp_t        cur;
   exp_t        exp_q[$];
   logic [7:0]  ref_mem [0:8191];
   logic [31:0] ram_mem [0:2047];

   dffram_lsu_if #(.ADDRESS_LENGTH(AL)) bus();

   dffram_lsu #(.ADDRESS_LENGTH(AL), .DATA_LENGTH(32)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus),
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // RAM model: byte write, registered read, output zeroed when disabled
   always @(posedge CLK) begin
      if (bus.ram_en) begin
         for (int b = 0; b < 4; b++)
            if (bus.ram_we[b]) ram_mem[bus.ram_a][8*b +: 8] <= bus.ram_di[8*b +: 8];
         bus.ram_do <= ram_mem[bus.ram_a];
      end else begin
         bus.ram_do <= 32'd0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // reference model: byte-addressed memory, little-endian, RISC-V size/extension rules
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                        output logic [3:0] mwe, output logic [31:0] mdi);
      int sz;
      bit sgn;
      bit legal;
      int base;
      logic [31:0] v;
      sz = 4; sgn = 0; legal = 1;
      if (we) begin
         legal = (f3 <= 3'd2);
         sz = 1 << f3[1:0];
      end else begin
         case (f3)
            3'd0: begin sz = 1; sgn = 1; end
            3'd1: begin sz = 2; sgn = 1; end
            3'd2: sz = 4;
            3'd4: sz = 1;
            3'd5: sz = 2;
            default: legal = 0;
         endcase
      end
      err = !legal || ((addr % 32'(sz)) != 0);
      rd = 32'd0; mwe = 4'd0; mdi = 32'd0;
      if (!err) begin
         base = int'(addr[12:0]);
         if (we) begin
            for (int k = 0; k < sz; k++) begin
               ref_mem[base+k] = wdata[8*k +: 8];
               mwe[(base+k)%4] = 1'b1;
            end
            mdi = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;
         end else begin
            v = 32'd0;
            for (int k = 0; k < sz; k++) v = v | (32'(ref_mem[base+k]) << (8*k));
            if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
            rd = v;
         end
      end
   endtask

   // driver: present one request, check the RAM drive in the accepting cycle, push expectation
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall);
      logic [31:0] rd, mdi;
      logic        err;
      logic [3:0]  mwe;
      exp_t        e;
      int          n;
      model(we, f3, addr, wdata, rd, err, mwe, mdi);
      @(negedge CLK);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      #1;
      n = 0;
      while (!bus.req_ready && n < 200) begin
         @(negedge CLK);
         #1;
         n++;
      end
      if (!bus.req_ready) begin
         check("req_timeout", 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      check("ram_en", 32'(bus.ram_en), 32'(!err));
      check("ram_we", 32'(bus.ram_we), 32'(mwe));
      check("ram_a", 32'(bus.ram_a), err ? 32'd0 : 32'(addr[12:2]));
      if (we || err) check("ram_di", bus.ram_di, mdi);
      stall_req = stall;
      @(posedge CLK);
      #1;
      e.rdata = rd;
      e.err   = err;
      e.due   = (!we && !err) ? cyc + 1 : cyc;
      exp_q.push_back(e);
      bus.req_valid = 1'b0;
   endtask

   // monitor: pops expectations when responses appear, drives rsp_ready with random backpressure
   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         @(negedge CLK);
         #1;
         if (RST) begin
            have_cur = 0;
            bus.rsp_ready = 1'b0;
            continue;
         end
         if (!(bus.req_valid && bus.req_ready))
            check("ram_idle", {27'd0, bus.ram_en, bus.ram_we}, 32'd0);
         if (bus.rsp_valid) begin
            if (!have_cur) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
                  bus.rsp_ready = 1'b1;
                  continue;
               end
               cur = exp_q.pop_front();
               have_cur = 1;
               check("latency", 32'(cyc), 32'(cur.due));
            end
            check("rsp_rdata", bus.rsp_rdata, cur.rdata);
            check("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            if (stall_req > 0) begin
               bus.rsp_ready = 1'b0;
               stall_req--;
            end else begin
               bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (bus.rsp_ready) have_cur = 0;
         end else begin
            if (have_cur) begin
               check("valid_dropped", 32'(bus.rsp_valid), 32'd1);
               have_cur = 0;
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
               check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
               void'(exp_q.pop_front());
            end
            bus.rsp_ready = ($urandom_range(0, 1) != 0);
         end
      end
   end

   initial begin
      for (int i = 0; i < 8192; i++) ref_mem[i] = 8'd0;
      for (int i = 0; i < 2048; i++) ram_mem[i] = 32'd0;
      RST = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      repeat (3) @(negedge CLK);
      bus.req_valid = 1'b1;
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_ram_en", 32'(bus.ram_en), 32'd0);
      bus.req_valid = 1'b0;
      @(posedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

      // directed: word, byte, halfword, errors, aliasing with backpressure
      issue(1, 3'd2, 32'h100, 32'hDEADBEEF, 0);
      issue(0, 3'd2, 32'h100, 32'h0, 0);
      issue(1, 3'd0, 32'h103, 32'h00000080, 0);
      issue(0, 3'd0, 32'h103, 32'h0, 0);
      issue(0, 3'd4, 32'h103, 32'h0, 0);
      issue(0, 3'd4, 32'h100, 32'h0, 0);
      issue(1, 3'd2, 32'h200, 32'h11223344, 0);
      issue(1, 3'd1, 32'h202, 32'h00008001, 0);
      issue(0, 3'd1, 32'h202, 32'h0, 0);
      issue(0, 3'd5, 32'h202, 32'h0, 0);
      issue(0, 3'd2, 32'h200, 32'h0, 0);
      issue(0, 3'd2, 32'h102, 32'h0, 0);
      issue(1, 3'd1, 32'h101, 32'hFFFFFFFF, 0);
      issue(0, 3'd3, 32'h100, 32'h0, 0);
      issue(1, 3'd5, 32'h104, 32'h12345678, 0);
      issue(0, 3'd2, 32'h100, 32'h0, 0);
      issue(0, 3'd2, 32'h2100, 32'h0, 5);

      // reset while a load sits in LOAD_WAIT
      issue(0, 3'd2, 32'h200, 32'h0, 0);
      #2;
      RST = 1'b1;
      exp_q.delete();
      stall_req = 0;
      repeat (2) @(posedge CLK);
      #3;
      check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      RST = 1'b0;
      #1;
      check("midrst_idle", 32'(bus.req_ready), 32'd1);
      repeat (3) @(negedge CLK);
      issue(0, 3'd2, 32'h100, 32'h0, 0);

      // random traffic over a small aliased window
      for (int i = 0; i < 200; i++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr;
         we   = ($urandom_range(0, 1) != 0);
         f3   = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
         addr = ($urandom() & 32'hFFFF_E000) | 32'($urandom_range(0, 127));
         issue(we, f3, addr, $urandom(), ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
      end

      begin
         int n;
         n = 0;
         while ((exp_q.size() > 0 || have_cur) && n < 1000) begin
            @(negedge CLK);
            n++;
         end
         if (exp_q.size() > 0 || have_cur) check("drain", 32'(exp_q.size()), 32'd0);
      end
      repeat (3) @(negedge CLK);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
